alu_exec_unit: RTL and testbench



---
 rtl/alu_exec_unit_if.sv | 27 ++
 rtl/alu_exec_unit.sv | 159 +++++++++++++++
 tb/tb_alu_exec_unit.sv | 335 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_exec_unit_if.sv
// Handshake bus between the ID/EX register, the execute ALU and the memory stage.
// The master drives operands and downstream ready; the slave is the ALU.
interface alu_exec_unit_if #(
  parameter int unsigned XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      alu_ctrl;
  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_b;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            zero;
  logic            illegal;

  modport master (
    output in_valid, alu_ctrl, src_a, src_b, flush, out_ready,
    input  in_ready, out_valid, result, zero, illegal
  );

  modport slave (
    input  in_valid, alu_ctrl, src_a, src_b, flush, out_ready,
    output in_ready, out_valid, result, zero, illegal
  );
endinterface

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle logic/arith ops, iterative 1-bit/cycle shifter,
// registered result with valid/ready handshake toward the memory stage.
module alu_exec_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  alu_exec_unit_if.slave  bus
);

  localparam int unsigned SHW = $clog2(XLEN);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_SLT  = 4'b0101;
  localparam logic [3:0] OP_SLTU = 4'b0110;
  localparam logic [3:0] OP_XOR  = 4'b1010;
  localparam logic [3:0] OP_SRA  = 4'b1011;
  localparam logic [3:0] OP_SRL  = 4'b1111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] work_q, work_d;
  logic [SHW-1:0]  cnt_q, cnt_d;
  logic            left_q, left_d;
  logic            arith_q, arith_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            zero_q, zero_d;
  logic            illegal_q, illegal_d;
  logic            out_valid_q, out_valid_d;

  logic            in_ready_c;
  logic            accept_c;
  logic [SHW-1:0]  shamt_c;
  logic            is_shift_c;
  logic [XLEN-1:0] alu_res_c;
  logic            alu_illegal_c;
  logic [XLEN-1:0] work_step_c;

  assign in_ready_c = (state_q == IDLE) | ((state_q == DONE) & bus.out_ready);
  assign accept_c   = bus.in_valid & in_ready_c & ~bus.flush;
  assign shamt_c    = bus.src_b[SHW-1:0];
  assign is_shift_c = (bus.alu_ctrl == OP_SLL) | (bus.alu_ctrl == OP_SRA) |
                      (bus.alu_ctrl == OP_SRL);

  // Single-cycle result; shifts only reach here with a zero amount, so pass src_a.
  always_comb begin
    alu_res_c     = '0;
    alu_illegal_c = 1'b0;
    unique case (bus.alu_ctrl)
      OP_ADD:  alu_res_c = bus.src_a + bus.src_b;
      OP_SUB:  alu_res_c = bus.src_a - bus.src_b;
      OP_AND:  alu_res_c = bus.src_a & bus.src_b;
      OP_OR:   alu_res_c = bus.src_a | bus.src_b;
      OP_XOR:  alu_res_c = bus.src_a ^ bus.src_b;
      OP_SLT:  alu_res_c = {{(XLEN-1){1'b0}}, ($signed(bus.src_a) < $signed(bus.src_b))};
      OP_SLTU: alu_res_c = {{(XLEN-1){1'b0}}, (bus.src_a < bus.src_b)};
      OP_SLL, OP_SRA, OP_SRL: alu_res_c = bus.src_a;
      default: alu_illegal_c = 1'b1;
    endcase
  end

  assign work_step_c = left_q ? {work_q[XLEN-2:0], 1'b0}
                              : {arith_q & work_q[XLEN-1], work_q[XLEN-1:1]};

  // Next-state and datapath update; flush outranks accept and out_ready.
  always_comb begin
    state_d     = state_q;
    work_d      = work_q;
    cnt_d       = cnt_q;
    left_d      = left_q;
    arith_d     = arith_q;
    result_d    = result_q;
    zero_d      = zero_q;
    illegal_d   = illegal_q;
    out_valid_d = out_valid_q;

    if (bus.flush) begin
      state_d     = IDLE;
      out_valid_d = 1'b0;
      cnt_d       = '0;
    end else if (accept_c) begin
      if (is_shift_c && (shamt_c != '0)) begin
        state_d     = SHIFT;
        work_d      = bus.src_a;
        cnt_d       = shamt_c;
        left_d      = (bus.alu_ctrl == OP_SLL);
        arith_d     = (bus.alu_ctrl == OP_SRA);
        out_valid_d = 1'b0;
      end else begin
        state_d     = DONE;
        result_d    = alu_res_c;
        zero_d      = (alu_res_c == '0);
        illegal_d   = alu_illegal_c;
        out_valid_d = 1'b1;
      end
    end else begin
      unique case (state_q)
        SHIFT: begin
          work_d = work_step_c;
          cnt_d  = cnt_q - SHW'(1);
          if (cnt_q == SHW'(1)) begin
            state_d     = DONE;
            result_d    = work_step_c;
            zero_d      = (work_step_c == '0);
            illegal_d   = 1'b0;
            out_valid_d = 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      work_q      <= '0;
      cnt_q       <= '0;
      left_q      <= 1'b0;
      arith_q     <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      illegal_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      work_q      <= work_d;
      cnt_q       <= cnt_d;
      left_q      <= left_d;
      arith_q     <= arith_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      illegal_q   <= illegal_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign bus.illegal   = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed scenarios plus randomized ops
// checked against a plain-arithmetic reference model.
module tb_alu_exec_unit;

  logic clk;
  logic reset;
  int   vectors;
  int   errors;

  alu_exec_unit_if #(.XLEN(32)) bus ();

  alu_exec_unit #(.XLEN(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: {illegal, result} straight from the opcode table.
  function automatic logic [32:0] ref_model(input logic [3:0] c, input logic [31:0] a,
                                            input logic [31:0] b);
    int unsigned sh;
    sh = int'(b[4:0]);
    case (c)
      4'd0:    return {1'b0, a + b};
      4'd1:    return {1'b0, a - b};
      4'd2:    return {1'b0, a & b};
      4'd3:    return {1'b0, a | b};
      4'd4:    return {1'b0, a << sh};
      4'd5:    return {1'b0, (($signed(a) < $signed(b)) ? 32'd1 : 32'd0)};
      4'd6:    return {1'b0, ((a < b) ? 32'd1 : 32'd0)};
      4'd10:   return {1'b0, a ^ b};
      4'd11:   return {1'b0, 32'($signed(a) >>> sh)};
      4'd15:   return {1'b0, a >> sh};
      default: return {1'b1, 32'd0};
    endcase
  endfunction

  function automatic int ref_latency(input logic [3:0] c, input logic [31:0] b);
    if ((c == 4'd4 || c == 4'd11 || c == 4'd15) && b[4:0] != 5'd0)
      return int'(b[4:0]) + 1;
    return 1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op from IDLE with out_ready=1 and check latency and outputs.
  task automatic run_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                        input string tag);
    logic [32:0] exp;
    int          exp_lat;
    int          lat;
    bit          ready_seen;
    exp     = ref_model(c, a, b);
    exp_lat = ref_latency(c, b);
    bus.alu_ctrl  = c;
    bus.src_a     = a;
    bus.src_b     = b;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    vectors++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s in_ready before accept: got %b want 1", tag, bus.in_ready);
    end
    tick();
    bus.in_valid = 1'b0;
    lat = 1;
    ready_seen = 1'b0;
    while (bus.out_valid !== 1'b1 && lat < 40) begin
      if (bus.in_ready !== 1'b0) ready_seen = 1'b1;
      tick();
      lat++;
    end
    vectors++;
    if (lat != exp_lat) begin
      errors++;
      $display("FAIL %s latency: got %0d want %0d", tag, lat, exp_lat);
    end
    vectors++;
    if (ready_seen) begin
      errors++;
      $display("FAIL %s in_ready while busy: got 1 want 0", tag);
    end
    vectors++;
    if (bus.result !== exp[31:0]) begin
      errors++;
      $display("FAIL %s result: got %h want %h", tag, bus.result, exp[31:0]);
    end
    vectors++;
    if (bus.zero !== (exp[31:0] == 32'd0)) begin
      errors++;
      $display("FAIL %s zero: got %b want %b", tag, bus.zero, (exp[31:0] == 32'd0));
    end
    vectors++;
    if (bus.illegal !== exp[32]) begin
      errors++;
      $display("FAIL %s illegal: got %b want %b", tag, bus.illegal, exp[32]);
    end
    tick();
    vectors++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s out_valid after consume: got %b want 0", tag, bus.out_valid);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.in_valid  = 1'b0;
    bus.alu_ctrl  = 4'd0;
    bus.src_a     = 32'd0;
    bus.src_b     = 32'd0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) tick();
    vectors++;
    if ({bus.out_valid, bus.zero, bus.illegal} !== 3'b000 || bus.result !== 32'd0) begin
      errors++;
      $display("FAIL reset outputs: got v=%b z=%b i=%b r=%h want 0 0 0 0",
               bus.out_valid, bus.zero, bus.illegal, bus.result);
    end
    reset = 1'b0;
    tick();
    vectors++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset in_ready: got %b want 1", bus.in_ready);
    end
  endtask

  task automatic test_directed();
    run_op(4'b0000, 32'hFFFF_FFFF, 32'd1, "add_wrap");
    run_op(4'b0001, 32'd5, 32'd7, "sub_neg");
    run_op(4'b0101, 32'hFFFF_FFFF, 32'd1, "slt");
    run_op(4'b0110, 32'hFFFF_FFFF, 32'd1, "sltu");
    run_op(4'b1011, 32'h8000_0000, 32'h0000_001F, "sra31");
    run_op(4'b1111, 32'h8000_0000, 32'h0000_001F, "srl31");
    run_op(4'b0100, 32'h1234_5678, 32'hFFFF_FFE0, "sll0");
    run_op(4'b0100, 32'h0000_0001, 32'h0000_001F, "sll31");
    run_op(4'b1000, 32'h1234_5678, 32'h0000_0001, "illegal");
  endtask

  task automatic test_back_to_back();
    bus.out_ready = 1'b1;
    bus.alu_ctrl  = 4'b0101;
    bus.src_a     = 32'hFFFF_FFFF;
    bus.src_b     = 32'd1;
    bus.in_valid  = 1'b1;
    tick();
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.result !== 32'd1) begin
      errors++;
      $display("FAIL b2b first: got v=%b r=%h want 1 00000001", bus.out_valid, bus.result);
    end
    bus.alu_ctrl = 4'b0110;
    vectors++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b in_ready in DONE: got %b want 1", bus.in_ready);
    end
    tick();
    bus.in_valid = 1'b0;
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.result !== 32'd0) begin
      errors++;
      $display("FAIL b2b second: got v=%b r=%h want 1 00000000", bus.out_valid, bus.result);
    end
    tick();
    vectors++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b drain: got %b want 0", bus.out_valid);
    end
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    bus.alu_ctrl  = 4'b0011;
    bus.src_a     = 32'h0000_00F0;
    bus.src_b     = 32'h0000_000F;
    bus.in_valid  = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.result !== 32'hFF) begin
        errors++;
        $display("FAIL stall cycle %0d: got v=%b rdy=%b r=%h want 1 0 000000ff",
                 i, bus.out_valid, bus.in_ready, bus.result);
      end
      tick();
    end
    bus.alu_ctrl  = 4'b0000;
    bus.src_a     = 32'd2;
    bus.src_b     = 32'd3;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    vectors++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall release in_ready: got %b want 1", bus.in_ready);
    end
    tick();
    bus.in_valid = 1'b0;
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.result !== 32'd5) begin
      errors++;
      $display("FAIL stall next op: got v=%b r=%h want 1 00000005", bus.out_valid, bus.result);
    end
    tick();
  endtask

  task automatic test_flush();
    bit seen;
    bus.out_ready = 1'b1;
    bus.alu_ctrl  = 4'b0100;
    bus.src_a     = 32'd1;
    bus.src_b     = 32'd10;
    bus.in_valid  = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    repeat (3) tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush shift: got v=%b rdy=%b want 0 1", bus.out_valid, bus.in_ready);
    end
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (bus.out_valid !== 1'b0) seen = 1'b1;
      tick();
    end
    vectors++;
    if (seen) begin
      errors++;
      $display("FAIL flush shift late out_valid: got 1 want 0");
    end
    run_op(4'b0000, 32'd2, 32'd3, "post_flush_add");

    // Flush in DONE drops the result and blocks a same-cycle accept.
    bus.out_ready = 1'b0;
    bus.alu_ctrl  = 4'b1010;
    bus.src_a     = 32'hAAAA_0000;
    bus.src_b     = 32'h0000_5555;
    bus.in_valid  = 1'b1;
    tick();
    bus.flush     = 1'b1;
    bus.out_ready = 1'b1;
    bus.alu_ctrl  = 4'b0000;
    tick();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    vectors++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush done: got v=%b want 0", bus.out_valid);
    end
    tick();
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush blocks accept: got v=%b rdy=%b want 0 1",
               bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_reset_mid_shift();
    run_op(4'b0000, 32'h0000_1000, 32'h0000_0234, "pre_reset_add");
    bus.alu_ctrl = 4'b1011;
    bus.src_a    = 32'h8000_0000;
    bus.src_b    = 32'd20;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    repeat (5) tick();
    reset = 1'b1;
    tick();
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.result !== 32'd0 || bus.zero !== 1'b0 ||
        bus.illegal !== 1'b0) begin
      errors++;
      $display("FAIL reset mid shift: got v=%b r=%h z=%b i=%b want 0 0 0 0",
               bus.out_valid, bus.result, bus.zero, bus.illegal);
    end
    reset = 1'b0;
    tick();
    vectors++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL after reset release: got rdy=%b v=%b want 1 0",
               bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_random();
    logic [3:0]  c;
    logic [31:0] a;
    logic [31:0] b;
    for (int i = 0; i < 40; i++) begin
      c = 4'($urandom_range(0, 15));
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 3) == 0) a = 32'd0;
      if ((c == 4'd4 || c == 4'd11 || c == 4'd15) && $urandom_range(0, 1) == 1)
        b = {b[31:5], 5'($urandom_range(0, 3))};
      if (c == 4'd1 && $urandom_range(0, 3) == 0) b = a;
      run_op(c, a, b, $sformatf("rand%0d_op%0h", i, c));
    end
  endtask

  initial begin
    vectors = 0;
    errors  = 0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_reset_mid_shift();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
